// File: rtl/bmp_loader_if.sv
// SDRAM write port used by bmp_loader: toggle request/acknowledge handshake plus the word address, byte strobes and data.
interface bmp_loader_if #(
  parameter int ADDR_W = 24
);
  logic              port_req;
  logic              port_ack;
  logic [ADDR_W-2:0] port_a;
  logic [1:0]        port_ds;
  logic [15:0]       port_d;
  logic              port_we;

  modport master (
    output port_req, port_a, port_ds, port_d, port_we,
    input  port_ack
  );

  modport slave (
    input  port_req, port_a, port_ds, port_d, port_we,
    output port_ack
  );
endinterface

// File: rtl/bmp_loader.sv
// Streams a 32-bpp BMP file from the ioctl download port, validates its header
// and writes the pixel bytes to SDRAM through a toggle-handshake write port.
module bmp_loader #(
  parameter int ADDR_W = 24
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ioctl_download,
  input  logic         ioctl_wr,
  input  logic [24:0]  ioctl_addr,
  input  logic [7:0]   ioctl_dout,
  bmp_loader_if.master sdram,
  output logic         bmp_valid,
  output logic         bmp_error,
  output logic [11:0]  bmp_width,
  output logic [11:0]  bmp_height,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, HEADER, PIXELS, DONE, ERROR} state_t;

  state_t            state_q, state_d;
  logic              download_q;
  logic [23:0]       offset_q, offset_d;
  logic [11:0]       width_q, width_d;
  logic [11:0]       height_q, height_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              port_req_q, port_req_d;
  logic [ADDR_W-2:0] port_a_q, port_a_d;
  logic [1:0]        port_ds_q, port_ds_d;
  logic [15:0]       port_d_q, port_d_d;
  logic              port_we_q, port_we_d;

  state_t            state_cur;
  logic              dl_rise;
  logic              pending;
  logic [ADDR_W-1:0] pix_addr;

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    width_d   = width_q;
    height_d  = height_q;
    valid_d   = valid_q;
    error_d   = error_q;
    port_req_d = port_req_q;
    port_a_d  = port_a_q;
    port_ds_d = port_ds_q;
    port_d_d  = port_d_q;

    dl_rise  = ioctl_download & ~download_q;
    pending  = port_req_q != sdram.port_ack;
    pix_addr = ADDR_W'(ioctl_addr - {1'b0, offset_q});

    // A new download restarts the loader; a byte strobed on the same edge is
    // handled as the first header byte of that new download.
    state_cur = state_q;
    if (dl_rise) begin
      state_cur = HEADER;
      state_d   = HEADER;
      valid_d   = 1'b0;
      error_d   = 1'b0;
      width_d   = '0;
      height_d  = '0;
      offset_d  = '0;
    end

    case (state_cur)
      HEADER: begin
        if (!ioctl_download) begin
          state_d = ERROR;
        end else if (ioctl_wr) begin
          case (ioctl_addr)
            25'd0:  if (ioctl_dout != 8'h42) state_d = ERROR;
            25'd1:  if (ioctl_dout != 8'h4D) state_d = ERROR;
            25'd10: offset_d[7:0]   = ioctl_dout;
            25'd11: offset_d[15:8]  = ioctl_dout;
            25'd12: offset_d[23:16] = ioctl_dout;
            25'd13: if (ioctl_dout != 8'h00) state_d = ERROR;
            25'd18: width_d[7:0]   = ioctl_dout;
            25'd19: width_d[11:8]  = ioctl_dout[3:0];
            25'd22: height_d[7:0]  = ioctl_dout;
            25'd23: height_d[11:8] = ioctl_dout[3:0];
            25'd28: if (ioctl_dout != 8'd32) state_d = ERROR;
            25'd29: state_d = (offset_d < 24'd30) ? ERROR : PIXELS;
            default: ;
          endcase
        end
      end

      PIXELS: begin
        // After the download window closes, the last write must be acknowledged
        // before the image can be declared complete.
        if (!ioctl_download) begin
          if (!pending) state_d = DONE;
        end else if (ioctl_wr) begin
          if (pending) begin
            state_d = ERROR;
          end else if (ioctl_addr >= {1'b0, offset_q}) begin
            port_req_d = ~port_req_q;
            port_a_d   = pix_addr[ADDR_W-1:1];
            port_ds_d  = {pix_addr[0], ~pix_addr[0]};
            port_d_d   = {ioctl_dout, ioctl_dout};
          end
        end
      end

      default: ;
    endcase

    if (state_d == ERROR) error_d = 1'b1;
    if (state_d == DONE)  valid_d = 1'b1;
    port_we_d = state_d == PIXELS;
    busy_d    = (state_d == HEADER) || (state_d == PIXELS);
  end

  // Reset re-aligns the request toggle with the acknowledge so nothing is left pending.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      download_q <= 1'b0;
      offset_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      port_req_q <= sdram.port_ack;
      port_a_q   <= '0;
      port_ds_q  <= '0;
      port_d_q   <= '0;
      port_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      download_q <= ioctl_download;
      offset_q   <= offset_d;
      width_q    <= width_d;
      height_q   <= height_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      port_req_q <= port_req_d;
      port_a_q   <= port_a_d;
      port_ds_q  <= port_ds_d;
      port_d_q   <= port_d_d;
      port_we_q  <= port_we_d;
    end
  end

  assign sdram.port_req = port_req_q;
  assign sdram.port_a   = port_a_q;
  assign sdram.port_ds  = port_ds_q;
  assign sdram.port_d   = port_d_q;
  assign sdram.port_we  = port_we_q;
  assign bmp_valid      = valid_q;
  assign bmp_error      = error_q;
  assign bmp_width      = width_q;
  assign bmp_height     = height_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_bmp_loader.sv
// Randomized self-checking bench for bmp_loader: BMP images are generated in a byte
// queue and the expected SDRAM writes and status are derived from the file contents.
module tb_bmp_loader;

  localparam int ADDR_W = 24;

  typedef struct packed {
    logic        we;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } req_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        bmp_valid;
  logic        bmp_error;
  logic [11:0] bmp_width;
  logic [11:0] bmp_height;
  logic        busy;

  logic        ack_r = 1'b0;
  logic        withhold = 1'b0;
  int          ack_cnt = 0;
  logic        last_req;

  logic [7:0]  img[$];
  req_t        cap_q[$];
  req_t        exp_q[$];
  logic        exp_valid;
  logic        exp_error;
  logic [11:0] exp_w;
  logic [11:0] exp_h;

  int n_compared = 0;
  int n_mismatched = 0;

  bmp_loader_if #(.ADDR_W(ADDR_W)) bus ();

  bmp_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .sdram          (bus.master),
    .bmp_valid      (bmp_valid),
    .bmp_error      (bmp_error),
    .bmp_width      (bmp_width),
    .bmp_height     (bmp_height),
    .busy           (busy)
  );

  assign bus.port_ack = ack_r;

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acknowledges each request three cycles after it appears.
  always @(posedge clk_sys) begin
    if (reset) begin
      ack_cnt <= 0;
    end else if (!withhold && bus.port_req != ack_r) begin
      if (ack_cnt == 2) begin
        ack_r   <= ~ack_r;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      last_req = bus.port_req;
    end else if (bus.port_req !== last_req) begin
      last_req = bus.port_req;
      cap_q.push_back('{we: bus.port_we, a: bus.port_a, ds: bus.port_ds, d: bus.port_d});
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int addr, input logic [7:0] data, input int gap);
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(addr);
    ioctl_dout = data;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (gap) @(posedge clk_sys);
  endtask

  task automatic buildImage(input int w, input int h, input int off, input int corrupt);
    img.delete();
    for (int i = 0; i < off + w * h * 4; i++) img.push_back(8'($urandom));
    img[0]  = 8'h42;
    img[1]  = 8'h4D;
    img[10] = 8'(off);
    img[11] = 8'h00;
    img[12] = 8'h00;
    img[13] = 8'h00;
    img[18] = 8'(w);
    img[19] = {4'($urandom_range(0, 15)), 4'(w >> 8)};
    img[22] = 8'(h);
    img[23] = {4'($urandom_range(0, 15)), 4'(h >> 8)};
    img[28] = 8'd32;
    case (corrupt)
      1: img[0]  = 8'h41;
      2: img[1]  = 8'h4C;
      3: img[13] = 8'($urandom_range(1, 255));
      4: img[28] = 8'd24;
      5: img[10] = 8'($urandom_range(0, 29));
      default: ;
    endcase
  endtask

  // Expected outcome when bytes 0..last have been streamed and the window then closes.
  task automatic computeExpected(input int last);
    int   off;
    int   p;
    logic ok;
    req_t r;
    off = int'({img[12], img[11], img[10]});
    exp_w = {img[19][3:0], img[18]};
    exp_h = {img[23][3:0], img[22]};
    ok = (last >= 29) && img[0] == 8'h42 && img[1] == 8'h4D && img[13] == 8'h00 &&
         img[28] == 8'd32 && off >= 30;
    exp_valid = ok;
    exp_error = !ok;
    exp_q.delete();
    if (ok) begin
      for (int i = off; i <= last; i++) begin
        p    = i - off;
        r.we = 1'b1;
        r.a  = 23'(p / 2);
        r.ds = (p % 2 == 1) ? 2'b10 : 2'b01;
        r.d  = {img[i], img[i]};
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic startDownload(input bit with_byte0);
    cap_q.delete();
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    if (with_byte0) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'd0;
      ioctl_dout = img[0];
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      repeat (3) @(posedge clk_sys);
    end
  endtask

  task automatic sendRange(input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(i, img[i], $urandom_range(3, 5));
  endtask

  task automatic endDownload();
    int n;
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    n = 0;
    while ((busy || bus.port_req !== ack_r) && n < 60) begin
      @(posedge clk_sys); #1;
      n++;
    end
    checkOutput("end_timeout", 64'(n >= 60), 64'd0);
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic checkResult();
    checkOutput("valid", 64'(bmp_valid), 64'(exp_valid));
    checkOutput("error", 64'(bmp_error), 64'(exp_error));
    checkOutput("busy_end", 64'(busy), 64'd0);
    checkOutput("we_end", 64'(bus.port_we), 64'd0);
    if (exp_valid) begin
      checkOutput("width", 64'(bmp_width), 64'(exp_w));
      checkOutput("height", 64'(bmp_height), 64'(exp_h));
    end
    checkOutput("req_count", 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      checkOutput("req_data", 64'(cap_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int h;
    int off;
    int corrupt;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;

    checkOutput("rst_valid", 64'(bmp_valid), 64'd0);
    checkOutput("rst_error", 64'(bmp_error), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_we", 64'(bus.port_we), 64'd0);
    checkOutput("rst_req", 64'(bus.port_req), 64'(ack_r));
    checkOutput("rst_width", 64'(bmp_width), 64'd0);

    $display("[TB] 4x2 image, offset 54");
    buildImage(4, 2, 54, 0);
    startDownload(0);
    applyStimulus(0, img[0], 3);
    checkOutput("busy_header", 64'(busy), 64'd1);
    sendRange(1, img.size() - 1);
    endDownload();
    computeExpected(img.size() - 1);
    checkResult();
    checkOutput("req32_count", 64'(cap_q.size()), 64'd32);
    if (cap_q.size() == 32) begin
      checkOutput("first_a", 64'(cap_q[0].a), 64'd0);
      checkOutput("first_ds", 64'(cap_q[0].ds), 64'b01);
      checkOutput("last_a", 64'(cap_q[31].a), 64'd15);
      checkOutput("last_ds", 64'(cap_q[31].ds), 64'b10);
    end
    checkOutput("w4", 64'(bmp_width), 64'd4);
    checkOutput("h2", 64'(bmp_height), 64'd2);
    applyStimulus(60, 8'hAA, 3);
    checkOutput("idle_wr_ignored", 64'(cap_q.size()), 64'd32);
    checkOutput("done_hold", 64'(bmp_valid), 64'd1);

    $display("[TB] bad signature byte");
    buildImage(4, 2, 54, 1);
    startDownload(0);
    applyStimulus(0, img[0], 0);
    checkOutput("sig_err_early", 64'(bmp_error), 64'd1);
    sendRange(1, img.size() - 1);
    endDownload();
    computeExpected(img.size() - 1);
    checkResult();

    $display("[TB] 24 bpp header");
    buildImage(3, 2, 54, 4);
    startDownload(0);
    sendRange(0, img.size() - 1);
    endDownload();
    computeExpected(img.size() - 1);
    checkResult();

    $display("[TB] overrun with ack withheld");
    buildImage(4, 2, 54, 0);
    startDownload(0);
    sendRange(0, 53);
    withhold = 1'b1;
    applyStimulus(54, img[54], 0);
    applyStimulus(55, img[55], 0);
    checkOutput("ovr_error", 64'(bmp_error), 64'd1);
    checkOutput("ovr_pending", 64'(bus.port_req != ack_r), 64'd1);
    checkOutput("ovr_count", 64'(cap_q.size()), 64'd1);
    withhold = 1'b0;
    repeat (8) @(posedge clk_sys);
    #1;
    checkOutput("ovr_settled", 64'(bus.port_req), 64'(ack_r));
    sendRange(56, 60);
    checkOutput("ovr_no_more", 64'(cap_q.size()), 64'd1);
    endDownload();
    checkOutput("ovr_valid", 64'(bmp_valid), 64'd0);
    checkOutput("ovr_error_hold", 64'(bmp_error), 64'd1);

    $display("[TB] truncated header");
    buildImage(2, 2, 40, 0);
    startDownload(0);
    sendRange(0, 20);
    endDownload();
    computeExpected(20);
    checkResult();

    $display("[TB] reset mid-pixels");
    buildImage(2, 2, 40, 0);
    startDownload(0);
    sendRange(0, 45);
    @(posedge clk_sys); #1;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;
    checkOutput("mid_rst_valid", 64'(bmp_valid), 64'd0);
    checkOutput("mid_rst_error", 64'(bmp_error), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_we", 64'(bus.port_we), 64'd0);
    checkOutput("mid_rst_req", 64'(bus.port_req), 64'(ack_r));
    checkOutput("mid_rst_width", 64'(bmp_width), 64'd0);
    buildImage(2, 3, 44, 0);
    startDownload(0);
    sendRange(0, img.size() - 1);
    endDownload();
    computeExpected(img.size() - 1);
    checkResult();

    $display("[TB] randomized images");
    for (int t = 0; t < 6; t++) begin
      w       = $urandom_range(1, 4);
      h       = $urandom_range(1, 3);
      off     = $urandom_range(30, 64);
      corrupt = $urandom_range(0, 8);
      if (corrupt > 5) corrupt = 0;
      buildImage(w, h, off, corrupt);
      if ($urandom_range(0, 1) == 1) begin
        startDownload(1);
        sendRange(1, img.size() - 1);
      end else begin
        startDownload(0);
        sendRange(0, img.size() - 1);
      end
      endDownload();
      computeExpected(img.size() - 1);
      checkResult();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
